// File: rtl/regbank_pkg.sv
// Shared definitions for the multi-port register bank.
//   state_e   : clear/run FSM encodings (one-hot; any other code is treated as CLEAR)
//   DEF_*     : default geometry of the MIPS ID-stage bank
//   clog2     : elaboration-time ceiling log2 helper
package regbank_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NUM_WR = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/regbank_read_port.sv
// Combinational read path for one read port.
//   i_rd_addr : read address
//   i_mem     : full register array contents
//   i_wr_vld  : per write port, write is accepted this cycle
//   i_wr_addr : per write port address
//   i_wr_data : per write port data
//   o_data    : value the rd_data register loads at the next edge
module regbank_read_port #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]                   i_rd_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]        i_mem,
    input  logic [NUM_WR-1:0]                   i_wr_vld,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]       i_wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]       i_wr_data,
    output logic [DATA_W-1:0]                   o_data
);

    logic w_masked;

    // Out-of-range and the hardwired zero register always read 0, even if a
    // same-cycle write targets them (such writes are dropped anyway).
    assign w_masked = ({1'b0, i_rd_addr} >= (ADDR_W+1)'(DEPTH)) ||
                      ((ZERO_REG != 0) && (i_rd_addr == '0));

    always_comb begin
        o_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (i_rd_addr == ADDR_W'(i)) o_data = i_mem[i];
        // Ascending scan: the highest-numbered matching write port wins.
        for (int j = 0; j < NUM_WR; j++)
            if (i_wr_vld[j] && (i_wr_addr[j] == i_rd_addr)) o_data = i_wr_data[j];
        if (w_masked) o_data = '0;
    end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port register file with write-to-read bypass, optional zero register
// and a sequenced array clear (after reset or on i_clear).
//   i_clk     : clock, all logic on posedge
//   i_rst_n   : asynchronous active-low reset
//   i_stall   : hold all read data (writes and clear sweep continue)
//   i_clear   : pulse to start a soft array clear
//   i_rd_addr : NUM_RD packed read addresses
//   o_rd_data : NUM_RD packed registered read data
//   i_wr_en   : per write port enable
//   i_wr_addr : NUM_WR packed write addresses
//   i_wr_data : NUM_WR packed write data
//   o_busy    : 1 while the array clear is in progress
module register_bank_mp
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_stall,
    input  logic                     i_clear,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    output logic                     o_busy
);

    localparam int CNT_W = ADDR_W + 1;

    state_e                          r_state;
    logic [CNT_W-1:0]                r_clr_cnt;
    logic                            r_busy;
    logic [NUM_RD-1:0][DATA_W-1:0]   r_rd_data;

    logic                            w_clr_mode;
    logic [DEPTH-1:0][DATA_W-1:0]    w_mem;
    logic [NUM_WR-1:0]               w_wr_vld;
    logic [NUM_WR-1:0][ADDR_W-1:0]   w_wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0]   w_wr_data;
    logic [NUM_RD-1:0][ADDR_W-1:0]   w_rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]   w_rd_next;

    assign w_wr_addr = i_wr_addr;
    assign w_wr_data = i_wr_data;
    assign w_rd_addr = i_rd_addr;
    assign o_rd_data = r_rd_data;
    assign o_busy    = r_busy;

    // Any code other than RUN (including corrupted encodings) behaves as CLEAR.
    assign w_clr_mode = (r_state != ST_RUN);

    for (genvar gj = 0; gj < NUM_WR; gj++) begin : g_wr_vld
        assign w_wr_vld[gj] = !w_clr_mode && i_wr_en[gj] &&
                              ({1'b0, w_wr_addr[gj]} < CNT_W'(DEPTH)) &&
                              !((ZERO_REG != 0) && (w_wr_addr[gj] == '0));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_clear) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == CNT_W'(DEPTH-1)) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    // Corrupted state: restart a full sweep.
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    // Storage is not reset; the sweep zeroes one word per cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [DATA_W-1:0] r_word;
        always_ff @(posedge i_clk) begin
            if (w_clr_mode) begin
                if (r_clr_cnt == CNT_W'(gi)) r_word <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++)
                    if (w_wr_vld[j] && (w_wr_addr[j] == ADDR_W'(gi))) r_word <= w_wr_data[j];
            end
        end
        assign w_mem[gi] = r_word;
    end

    for (genvar gk = 0; gk < NUM_RD; gk++) begin : g_rd
        regbank_read_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .i_rd_addr (w_rd_addr[gk]),
            .i_mem     (w_mem),
            .i_wr_vld  (w_wr_vld),
            .i_wr_addr (w_wr_addr),
            .i_wr_data (w_wr_data),
            .o_data    (w_rd_next[gk])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rd_data <= '0;
        else if (!i_stall)
            r_rd_data <= w_clr_mode ? '0 : w_rd_next;
    end

endmodule

// File: tb/tb_register_bank_mp.sv
module tb_register_bank_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        clear = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        busy;

    logic        stall24 = 1'b0;
    logic        clear24 = 1'b0;
    logic [9:0]  rd_addr24 = '0;
    logic [63:0] rd_data24;
    logic [0:0]  wr_en24 = '0;
    logic [4:0]  wr_addr24 = '0;
    logic [31:0] wr_data24 = '0;
    logic        busy24;

    int nvec = 0;
    int nerr = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    register_bank_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_clear(clear),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data), .i_wr_en(wr_en),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_busy(busy)
    );

    register_bank_mp #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1)) dut24 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall24), .i_clear(clear24),
        .i_rd_addr(rd_addr24), .o_rd_data(rd_data24), .i_wr_en(wr_en24),
        .i_wr_addr(wr_addr24), .i_wr_data(wr_data24), .o_busy(busy24)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle on the 32-deep bank: drive, push expectation, clock, pop/compare.
    task automatic cyc(input string tag, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [31:0] e0, input logic [31:0] e1);
        wr_en   = we;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        rd_addr = {ra1, ra0};
        exp_q.push_back({e1, e0});
        tag_q.push_back(tag);
        tick();
        wr_en = '0;
        clear = 1'b0;
        chk(tag_q.pop_front(), rd_data, exp_q.pop_front());
    endtask

    task automatic cyc24(input string tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [31:0] e0, input logic [31:0] e1);
        wr_en24   = we;
        wr_addr24 = wa;
        wr_data24 = wd;
        rd_addr24 = {ra1, ra0};
        exp_q.push_back({e1, e0});
        tag_q.push_back(tag);
        tick();
        wr_en24 = '0;
        chk(tag_q.pop_front(), rd_data24, exp_q.pop_front());
    endtask

    // Idle both banks for 40 cycles, recording the first cycle busy reads 0.
    task automatic sweep_len(output int n32, output int n24);
        n32 = 0;
        n24 = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (!busy && n32 == 0) n32 = k;
            if (!busy24 && n24 == 0) n24 = k;
        end
    endtask

    initial begin
        int n32, n24, nb;

        // Reset held two cycles
        tick();
        tick();
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h1);
        rst_n = 1'b1;
        sweep_len(n32, n24);
        chk("init_clear_len32", 64'(n32), 64'd32);
        chk("init_clear_len24", 64'(n24), 64'd24);
        for (int a = 0; a < 32; a += 2)
            cyc("init_rd_zero", 2'b00, 0, 0, 0, 0, 5'(a), 5'(a + 1), 0, 0);

        // Basic write/read and zero register
        cyc("wr_r5", 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        cyc("rd_r5", 2'b00, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0);
        cyc("wr_r0_bypass", 2'b01, 0, 32'h1, 0, 0, 0, 5, 0, 32'hDEADBEEF);
        cyc("rd_r0", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

        // Same-cycle bypass on both ports
        cyc("bypass_r7", 2'b01, 7, 32'h1234, 0, 0, 7, 7, 32'h1234, 32'h1234);

        // Two ports to one address: port 1 wins, in bypass and in storage
        cyc("dual_wr_r3", 2'b11, 3, 32'hA, 3, 32'hB, 3, 3, 32'hB, 32'hB);
        cyc("rd_r3", 2'b00, 0, 0, 0, 0, 3, 7, 32'hB, 32'h1234);
        cyc("rd_r3b", 2'b00, 0, 0, 0, 0, 3, 3, 32'hB, 32'hB);

        // Stall: outputs hold while a write lands
        stall = 1'b1;
        cyc("stall_hold1", 2'b10, 0, 0, 9, 32'h99, 9, 5, 32'hB, 32'hB);
        cyc("stall_hold2", 2'b00, 0, 0, 0, 0, 5, 7, 32'hB, 32'hB);
        cyc("stall_hold3", 2'b00, 0, 0, 0, 0, 7, 9, 32'hB, 32'hB);
        stall = 1'b0;
        cyc("post_stall", 2'b00, 0, 0, 0, 0, 9, 5, 32'h99, 32'hDEADBEEF);

        // Fill r1..r31, then soft clear
        for (int a = 1; a < 32; a += 2)
            cyc("fill", (a < 31) ? 2'b11 : 2'b01, 5'(a), 32'h100 + 32'(a),
                5'(a + 1), 32'h100 + 32'(a + 1), 0, 0, 0, 0);
        cyc("fill_rd", 2'b00, 0, 0, 0, 0, 17, 31, 32'h111, 32'h11F);
        clear = 1'b1;
        cyc("clear_cycle_wr", 2'b01, 2, 32'h77, 0, 0, 2, 31, 32'h77, 32'h11F);
        nb = 0;
        for (int k = 1; k <= 32; k++) begin
            cyc("clear_rd_zero", 2'b01, 4, 32'hBAD, 0, 0, 4, 6, 0, 0);
            if (!busy && nb == 0) nb = k;
        end
        chk("soft_clear_len", 64'(nb), 64'd32);
        for (int a = 0; a < 32; a += 2)
            cyc("post_clear_zero", 2'b00, 0, 0, 0, 0, 5'(a), 5'(a + 1), 0, 0);

        // Reset 10 cycles into a clear restarts the sweep
        cyc("wr_r8", 2'b01, 8, 32'h88, 0, 0, 0, 0, 0, 0);
        cyc("rd_r8", 2'b00, 0, 0, 0, 0, 8, 8, 32'h88, 32'h88);
        clear = 1'b1;
        cyc("clear2", 2'b00, 0, 0, 0, 0, 8, 0, 32'h88, 0);
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_busy", {63'h0, busy}, 64'h1);
        chk("midclr_rst_rd", rd_data, 64'h0);
        tick();
        rst_n = 1'b1;
        sweep_len(n32, n24);
        chk("restart_len32", 64'(n32), 64'd32);
        chk("restart_len24", 64'(n24), 64'd24);
        cyc("rd_r8_after", 2'b00, 0, 0, 0, 0, 8, 9, 0, 0);

        // DEPTH=24 bank: out-of-range addresses and short sweep
        cyc24("d24_wr30", 1'b1, 30, 32'h3030, 30, 23, 0, 0);
        cyc24("d24_wr23", 1'b1, 23, 32'h2323, 30, 0, 0, 0);
        cyc24("d24_rd", 1'b0, 0, 0, 23, 30, 32'h2323, 0);
        clear24 = 1'b1;
        tick();
        clear24 = 1'b0;
        nb = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (!busy24 && nb == 0) nb = k;
        end
        chk("d24_clear_len", 64'(nb), 64'd24);
        cyc24("d24_rd_cleared", 1'b0, 0, 0, 23, 22, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
